// File: rtl/mem_init_engine.sv
// mem_init_engine
// Sweeps a latched address range and writes one generated word per write slot
// into a single-port memory. A run is controlled by start/abort and reported
// through busy and a sticky done flag. Every output is registered.

module mem_init_engine #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 6,
    parameter int WE_GAP    = 8,
    parameter int ROW_SHIFT = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              busy,
    output logic              done
);

    localparam int GAP_W = $clog2(WE_GAP) + 1;
    localparam int H     = DATA_W / 2;
    localparam int L     = DATA_W - H;

    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(WE_GAP - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Word written at address a for the latched pattern selection.
    function automatic logic [DATA_W-1:0] pattern(
        input logic [1:0]        m,
        input logic [DATA_W-1:0] fv,
        input logic [ADDR_W-1:0] a
    );
        logic [DATA_W-1:0] word;
        case (m)
            2'd0:    word = fv;
            2'd1:    word = a[DATA_W-1:0];
            2'd2:    word = (a[0] ^ a[ROW_SHIFT]) ? ~fv : fv;
            2'd3:    word = {a[ROW_SHIFT+H-1:ROW_SHIFT], a[L-1:0]};
            default: word = fv;
        endcase
        return word;
    endfunction

    state_t              state_r, state_s;
    logic [1:0]          mode_r,  mode_s;
    logic [DATA_W-1:0]   fill_r,  fill_s;
    logic [ADDR_W-1:0]   base_r,  base_s;
    logic [ADDR_W:0]     len_r,   len_s;
    logic [GAP_W-1:0]    gap_r,   gap_s;
    logic [ADDR_W:0]     entry_r, entry_s;
    logic [ADDR_W-1:0]   addr_r,  addr_s;
    logic [DATA_W-1:0]   data_r,  data_s;
    logic                we_r,    we_s;
    logic                busy_r,  busy_s;
    logic                done_r,  done_s;

    logic                load_s;
    logic                finish_s;
    logic [ADDR_W-1:0]   cur_addr_s;
    logic [ADDR_W-1:0]   span_s;

    // Next-state and datapath decode; outputs lag the state by one edge so
    // busy rises one clock after start is accepted.
    always_comb begin
        state_s    = state_r;
        load_s     = 1'b0;
        mode_s     = mode_r;
        fill_s     = fill_r;
        base_s     = base_r;
        len_s      = len_r;
        gap_s      = gap_r;
        entry_s    = entry_r;
        addr_s     = addr_r;
        data_s     = data_r;
        we_s       = 1'b0;
        busy_s     = busy_r;
        done_s     = done_r;
        finish_s   = (entry_r == len_r);
        cur_addr_s = base_r + entry_r[ADDR_W-1:0];
        span_s     = last_addr - base_addr;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load_s  = 1'b1;
                    state_s = ST_RUN;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    busy_s  = 1'b0;
                    done_s  = 1'b0;
                end else if (finish_s) begin
                    busy_s = 1'b0;
                    done_s = 1'b1;
                    if (start) begin
                        // Back-to-back run accepted on the completing edge.
                        load_s  = 1'b1;
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_RUN;
                    busy_s  = 1'b1;
                    done_s  = 1'b0;
                    addr_s  = cur_addr_s;
                    data_s  = pattern(mode_r, fill_r, cur_addr_s);
                    we_s    = (gap_r == GAP_LAST);
                    if (gap_r == GAP_LAST) begin
                        gap_s   = '0;
                        entry_s = entry_r + CNT_ONE;
                    end else begin
                        gap_s   = gap_r + GAP_ONE;
                        entry_s = entry_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase

        if (load_s) begin
            mode_s  = mode;
            fill_s  = fill_value;
            base_s  = base_addr;
            // Extra bit keeps the full-range count (2^ADDR_W) representable.
            len_s   = {1'b0, span_s} + CNT_ONE;
            gap_s   = '0;
            entry_s = '0;
        end else begin
            len_s   = len_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latched run configuration, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r  <= 2'd0;
            fill_r  <= '0;
            base_r  <= '0;
            len_r   <= '0;
            gap_r   <= '0;
            entry_r <= '0;
            addr_r  <= '0;
            data_r  <= '0;
            we_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            mode_r  <= mode_s;
            fill_r  <= fill_s;
            base_r  <= base_s;
            len_r   <= len_s;
            gap_r   <= gap_s;
            entry_r <= entry_s;
            addr_r  <= addr_s;
            data_r  <= data_s;
            we_r    <= we_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign mem_addr = addr_r;
    assign mem_data = data_r;
    assign mem_we   = we_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_mem_init_engine.sv
// Directed bench for mem_init_engine: a default-parameter instance (a_*) and
// a WE_GAP=1 instance (b_*). Edge numbering follows start: "edge 0" is the
// clock edge that samples start; checks run 1 time unit after each edge.

module tb_mem_init_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_start = 1'b0, a_abort = 1'b0;
    logic [1:0]  a_mode = 2'd0;
    logic [5:0]  a_fill = 6'd0;
    logic [10:0] a_base = 11'd0, a_last = 11'd0;
    logic [10:0] a_addr;
    logic [5:0]  a_data;
    logic        a_we, a_busy, a_done;

    logic        b_start = 1'b0, b_abort = 1'b0;
    logic [1:0]  b_mode = 2'd0;
    logic [5:0]  b_fill = 6'd0;
    logic [10:0] b_base = 11'd0, b_last = 11'd0;
    logic [10:0] b_addr;
    logic [5:0]  b_data;
    logic        b_we, b_busy, b_done;

    int n_cmp = 0;
    int n_err = 0;
    int ed    = 0;

    // Monitor state (written only by the monitor process).
    int          a_we_cnt  = 0;
    int          a_gap_bad = 0;
    int          a_run_cyc = 0;
    logic [5:0]  a_cap     = 6'd0;
    int          we_base;

    mem_init_engine #(.ADDR_W(11), .DATA_W(6), .WE_GAP(8), .ROW_SHIFT(6)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .mode(a_mode),
        .fill_value(a_fill), .base_addr(a_base), .last_addr(a_last),
        .mem_addr(a_addr), .mem_data(a_data), .mem_we(a_we),
        .busy(a_busy), .done(a_done)
    );

    mem_init_engine #(.ADDR_W(11), .DATA_W(6), .WE_GAP(1), .ROW_SHIFT(6)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .mode(b_mode),
        .fill_value(b_fill), .base_addr(b_base), .last_addr(b_last),
        .mem_addr(b_addr), .mem_data(b_data), .mem_we(b_we),
        .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    // Count write pulses of instance A, flag any pulse not on a slot boundary
    // (busy clock count a multiple of 8), capture data written to 0x1C5.
    always @(negedge clk) begin
        if (a_busy) a_run_cyc = a_run_cyc + 1;
        else        a_run_cyc = 0;
        if (a_we) begin
            a_we_cnt = a_we_cnt + 1;
            if (!a_busy || (a_run_cyc % 8) != 0) a_gap_bad = a_gap_bad + 1;
            if (a_addr == 11'h1C5) a_cap = a_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ed++;
    endtask

    task automatic go_to(input int e);
        while (ed < e) tick();
    endtask

    task automatic start_a(input logic [1:0] m, input logic [5:0] f,
                           input logic [10:0] b, input logic [10:0] l);
        a_mode = m; a_fill = f; a_base = b; a_last = l;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        ed = 0;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_addr", 32'(a_addr), 32'h0);
        check("rst_data", 32'(a_data), 32'h0);
        check("rst_we",   32'(a_we),   32'h0);
        check("rst_busy", 32'(a_busy), 32'h0);
        check("rst_done", 32'(a_done), 32'h0);

        // ---------------- WE_GAP=1, mode 0, 10..12 ----------------
        b_mode = 2'd0; b_fill = 6'h2A; b_base = 11'd10; b_last = 11'd12;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        ed = 0;
        check("g1_busy_e0", 32'(b_busy), 32'h0);
        for (int n = 0; n < 3; n++) begin
            tick();
            check("g1_we",   32'(b_we),   32'h1);
            check("g1_addr", 32'(b_addr), 32'(10 + n));
            check("g1_data", 32'(b_data), 32'h2A);
            check("g1_busy", 32'(b_busy), 32'h1);
        end
        tick();
        check("g1_we_end",   32'(b_we),   32'h0);
        check("g1_busy_end", 32'(b_busy), 32'h0);
        check("g1_done_end", 32'(b_done), 32'h1);
        check("g1_addr_hold", 32'(b_addr), 32'd12);

        // ---------------- checkerboard, fill 0x15, 63..65 ----------------
        // a[0]^a[6]: 63 -> 1^0=1 (0x2A), 64 -> 0^1=1 (0x2A), 65 -> 1^1=0 (0x15)
        start_a(2'd2, 6'h15, 11'd63, 11'd65);
        tick();
        check("ck_busy_e1", 32'(a_busy), 32'h1);
        check("ck_we_e1",   32'(a_we),   32'h0);
        check("ck_addr_e1", 32'(a_addr), 32'd63);
        for (int n = 0; n < 3; n++) begin
            logic [5:0] exp_d;
            exp_d = (n == 2) ? 6'h15 : 6'h2A;
            go_to((n + 1) * 8 - 1);
            check("ck_we_pre", 32'(a_we), 32'h0);
            tick();
            check("ck_we",   32'(a_we),   32'h1);
            check("ck_addr", 32'(a_addr), 32'(63 + n));
            check("ck_data", 32'(a_data), 32'(exp_d));
        end
        tick();
        check("ck_done", 32'(a_done), 32'h1);
        check("ck_busy", 32'(a_busy), 32'h0);

        // ---------------- wrap 2046..1, mode 1 ----------------
        start_a(2'd1, 6'h00, 11'd2046, 11'd1);
        check("wr_done_e0", 32'(a_done), 32'h1);
        tick();
        check("wr_done_e1", 32'(a_done), 32'h0);
        check("wr_busy_e1", 32'(a_busy), 32'h1);
        for (int n = 0; n < 4; n++) begin
            logic [10:0] exp_a;
            exp_a = 11'(2046 + n);
            go_to((n + 1) * 8);
            check("wr_we",   32'(a_we),   32'h1);
            check("wr_addr", 32'(a_addr), 32'(exp_a));
            check("wr_data", 32'(a_data), 32'(exp_a[5:0]));
        end
        tick();
        check("wr_done", 32'(a_done), 32'h1);
        repeat (5) tick();
        check("wr_done_sticky", 32'(a_done), 32'h1);

        // ---------------- abort after 2nd write, retrigger ignored ----------------
        we_base = a_we_cnt;
        start_a(2'd0, 6'h11, 11'd100, 11'd109);
        go_to(2);
        a_start = 1'b1; a_base = 11'd500; a_mode = 2'd1;
        tick();
        a_start = 1'b0;
        go_to(8);
        check("ab_addr1", 32'(a_addr), 32'd100);
        check("ab_data1", 32'(a_data), 32'h11);
        go_to(16);
        check("ab_addr2", 32'(a_addr), 32'd101);
        check("ab_we2",   32'(a_we),   32'h1);
        go_to(23);
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        check("ab_we",   32'(a_we),   32'h0);
        check("ab_busy", 32'(a_busy), 32'h0);
        check("ab_done", 32'(a_done), 32'h0);
        repeat (20) tick();
        check("ab_we_count", 32'(a_we_cnt - we_base), 32'd2);
        check("ab_busy_late", 32'(a_busy), 32'h0);

        // ---------------- reset mid-run ----------------
        start_a(2'd1, 6'h00, 11'd200, 11'd300);
        go_to(7);
        rst = 1'b1;
        tick();
        check("mr_addr", 32'(a_addr), 32'h0);
        check("mr_data", 32'(a_data), 32'h0);
        check("mr_we",   32'(a_we),   32'h0);
        check("mr_busy", 32'(a_busy), 32'h0);
        check("mr_done", 32'(a_done), 32'h0);
        we_base = a_we_cnt;
        rst = 1'b0;
        repeat (30) tick();
        check("mr_no_we", 32'(a_we_cnt - we_base), 32'd0);

        // Fresh run after reset; abort held with start (start wins).
        a_abort = 1'b1;
        start_a(2'd3, 6'h00, 11'd5, 11'd6);
        a_abort = 1'b0;
        tick();
        check("fr_busy", 32'(a_busy), 32'h1);
        go_to(8);
        check("fr_addr1", 32'(a_addr), 32'd5);
        check("fr_data1", 32'(a_data), 32'h05);
        check("fr_we1",   32'(a_we),   32'h1);
        go_to(16);
        check("fr_addr2", 32'(a_addr), 32'd6);
        check("fr_data2", 32'(a_data), 32'h06);
        tick();
        check("fr_done", 32'(a_done), 32'h1);

        // ---------------- full range, tile index ----------------
        we_base = a_we_cnt;
        start_a(2'd3, 6'h00, 11'd0, 11'd2047);
        go_to(16384);
        check("fl_busy_last", 32'(a_busy), 32'h1);
        check("fl_done_last", 32'(a_done), 32'h0);
        tick();
        check("fl_busy_end", 32'(a_busy), 32'h0);
        check("fl_done_end", 32'(a_done), 32'h1);
        check("fl_addr_end", 32'(a_addr), 32'd2047);
        check("fl_data_end", 32'(a_data), 32'h3F);
        tick();
        check("fl_we_count", 32'(a_we_cnt - we_base), 32'd2048);
        check("fl_1c5_data", 32'(a_cap), 32'h3D);
        check("slot_spacing", 32'(a_gap_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
